// File: rtl/dat_read_buffer.sv
// dat_read_buffer
// Word FIFO sitting directly behind the DAT-line receiver. Incoming words are
// staged speculatively and only become visible to the host once their block
// closes with clean CRC and end bit. Bad blocks are rewound away. Committed
// words are presented one per host read on the Buffer Data Port.
//
// Handshake: wr_valid_i is a one-cycle strobe with no back-pressure. Flow
// control is pause_o, which stops the SD clock before the next block begins.
// rd_en_i is a one-cycle read strobe. It is honoured only while
// buf_rd_enable_o=1, and it must not be issued on back-to-back cycles.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           synchronous flush; overrides every other input
//   block_size_i      block length in bytes (static during a transfer)
//   wr_valid_i/wr_data_i                      receiver word strobe and data
//   block_done_i, crc_err_i, end_bit_err_i    end-of-block status
//   rd_en_i / rd_data_o                       host Buffer Data Port read
//   buf_rd_enable_o   a committed block is unread
//   buf_rd_ready_o    pulse: a new block became the head readable block
//   pause_o           hold the SD clock before the next block
//   blk_err_o         pulse: block discarded
//   overflow_o        sticky: write arrived while full
//   underrun_o        pulse: read with nothing committed
module dat_read_buffer #(
    parameter int DepthWords      = 256,
    parameter int MaxBlockBitSize = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    input  logic                       wr_valid_i,
    input  logic [31:0]                wr_data_i,
    input  logic                       block_done_i,
    input  logic                       crc_err_i,
    input  logic                       end_bit_err_i,
    input  logic                       rd_en_i,
    output logic [31:0]                rd_data_o,
    output logic                       buf_rd_enable_o,
    output logic                       buf_rd_ready_o,
    output logic                       pause_o,
    output logic                       blk_err_o,
    output logic                       overflow_o,
    output logic                       underrun_o
);

    localparam int AW = $clog2(DepthWords);
    localparam int PW = AW + 1;
    localparam int CW = MaxBlockBitSize - 1;
    localparam logic [31:0] DEPTH_U = DepthWords;

    logic [31:0]   r_mem [DepthWords];

    logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [AW:0]   r_cb;
    logic [CW-1:0] r_rd_word_cnt;
    logic [31:0]   r_rd_data;
    logic          r_rd_enable, r_rd_ready, r_pause, r_blk_err, r_overflow, r_underrun;

    logic [MaxBlockBitSize:0] w_bs_plus3;
    logic [CW-1:0] w_wpb;
    logic [PW-1:0] w_occ, w_occ_n, w_wr_post, w_wr_ptr_n, w_commit_ptr_n, w_rd_ptr_n;
    logic          w_full, w_wr_accept, w_overflow_evt;
    logic          w_blk_bad, w_commit;
    logic          w_rd_fire, w_rd_last, w_blk_finish;
    logic [CW-1:0] w_rd_word_cnt_n;
    logic [AW:0]   w_cb_n;
    logic [31:0]   w_rd_data_n, w_free_n;
    logic          w_pause_n, w_rd_ready_n;

    // Words per block = ceil(bytes/4).
    assign w_bs_plus3 = {1'b0, block_size_i} + {{(MaxBlockBitSize-1){1'b0}}, 2'b11};
    assign w_wpb      = w_bs_plus3[MaxBlockBitSize:2];

    // Write side. Occupancy is measured against rd_ptr, so speculative words
    // of the block in flight count towards full.
    assign w_occ          = r_wr_ptr - r_rd_ptr;
    assign w_full         = (w_occ == {1'b1, {AW{1'b0}}});
    assign w_wr_accept    = wr_valid_i && !w_full;
    assign w_overflow_evt = wr_valid_i && w_full;
    assign w_wr_post      = r_wr_ptr + {{AW{1'b0}}, w_wr_accept};

    // A word strobed together with block_done_i belongs to the closing block,
    // so a bad block rewinds past it and a good block commits it.
    assign w_blk_bad      = block_done_i && (crc_err_i || end_bit_err_i);
    assign w_commit       = block_done_i && !w_blk_bad;
    assign w_wr_ptr_n     = w_blk_bad ? r_commit_ptr : w_wr_post;
    assign w_commit_ptr_n = w_commit ? w_wr_post : r_commit_ptr;

    // Read side.
    assign w_rd_fire       = rd_en_i && (r_cb != '0);
    assign w_rd_last       = (r_rd_word_cnt == (w_wpb - 1'b1));
    assign w_blk_finish    = w_rd_fire && w_rd_last;
    assign w_rd_ptr_n      = r_rd_ptr + {{AW{1'b0}}, w_rd_fire};
    assign w_rd_word_cnt_n = !w_rd_fire ? r_rd_word_cnt :
                             (w_rd_last ? '0 : r_rd_word_cnt + 1'b1);

    always_comb begin
        w_cb_n = r_cb;
        case ({w_commit, w_blk_finish})
            2'b10:   w_cb_n = r_cb + 1'b1;
            2'b01:   w_cb_n = r_cb - 1'b1;
            default: w_cb_n = r_cb;
        endcase
    end

    // The head word can be the one being written this very cycle (a one-word
    // block committed into an empty buffer), so forward it around the memory.
    always_comb begin
        w_rd_data_n = '0;
        if (w_cb_n != '0) begin
            if (w_wr_accept && (r_wr_ptr == w_rd_ptr_n))
                w_rd_data_n = wr_data_i;
            else
                w_rd_data_n = r_mem[w_rd_ptr_n[AW-1:0]];
        end
    end

    // A block becomes head-readable either when the buffer goes non-empty or
    // when finishing one block leaves another committed behind it.
    assign w_rd_ready_n = (w_cb_n != '0) && ((r_cb == '0) || w_blk_finish);

    // Pause is only re-evaluated between blocks so the SD clock is never
    // stopped mid-block.
    assign w_occ_n   = w_wr_ptr_n - w_rd_ptr_n;
    assign w_free_n  = DEPTH_U - {{(32-PW){1'b0}}, w_occ_n};
    assign w_pause_n = (w_wr_ptr_n == w_commit_ptr_n) ?
                       (w_free_n < {{(32-CW){1'b0}}, w_wpb}) : r_pause;

    always_ff @(posedge clk_i) begin
        if (w_wr_accept && !clear_i)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_rd_ptr      <= '0;
            r_cb          <= '0;
            r_rd_word_cnt <= '0;
            r_rd_data     <= '0;
            r_rd_enable   <= 1'b0;
            r_rd_ready    <= 1'b0;
            r_pause       <= 1'b0;
            r_blk_err     <= 1'b0;
            r_overflow    <= 1'b0;
            r_underrun    <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_rd_ptr      <= '0;
            r_cb          <= '0;
            r_rd_word_cnt <= '0;
            r_rd_data     <= '0;
            r_rd_enable   <= 1'b0;
            r_rd_ready    <= 1'b0;
            r_pause       <= 1'b0;
            r_blk_err     <= 1'b0;
            r_overflow    <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_n;
            r_commit_ptr  <= w_commit_ptr_n;
            r_rd_ptr      <= w_rd_ptr_n;
            r_cb          <= w_cb_n;
            r_rd_word_cnt <= w_rd_word_cnt_n;
            r_rd_data     <= w_rd_data_n;
            r_rd_enable   <= (w_cb_n != '0);
            r_rd_ready    <= w_rd_ready_n;
            r_pause       <= w_pause_n;
            r_blk_err     <= w_blk_bad;
            r_overflow    <= r_overflow | w_overflow_evt;
            r_underrun    <= rd_en_i && (r_cb == '0);
        end
    end

    assign rd_data_o       = r_rd_data;
    assign buf_rd_enable_o = r_rd_enable;
    assign buf_rd_ready_o  = r_rd_ready;
    assign pause_o         = r_pause;
    assign blk_err_o       = r_blk_err;
    assign overflow_o      = r_overflow;
    assign underrun_o      = r_underrun;

endmodule

// File: tb/tb_dat_read_buffer.sv
// Directed bench for dat_read_buffer: single block, bad-block discard, pause
// back-pressure, odd block size, interleaved traffic with commit/finish
// coincidence, and misuse (underrun, overflow, clear).
module tb_dat_read_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic [9:0]  block_size_i;
  logic        wr_valid_i;
  logic [31:0] wr_data_i;
  logic        block_done_i;
  logic        crc_err_i;
  logic        end_bit_err_i;
  logic        rd_en_i;
  logic [31:0] rd_data_o;
  logic        buf_rd_enable_o;
  logic        buf_rd_ready_o;
  logic        pause_o;
  logic        blk_err_o;
  logic        overflow_o;
  logic        underrun_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dat_read_buffer #(.DepthWords(256), .MaxBlockBitSize(10)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .block_size_i    (block_size_i),
    .wr_valid_i      (wr_valid_i),
    .wr_data_i       (wr_data_i),
    .block_done_i    (block_done_i),
    .crc_err_i       (crc_err_i),
    .end_bit_err_i   (end_bit_err_i),
    .rd_en_i         (rd_en_i),
    .rd_data_o       (rd_data_o),
    .buf_rd_enable_o (buf_rd_enable_o),
    .buf_rd_ready_o  (buf_rd_ready_o),
    .pause_o         (pause_o),
    .blk_err_o       (blk_err_o),
    .overflow_o      (overflow_o),
    .underrun_o      (underrun_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, then return them to idle
  task automatic drive(input logic wv, input logic [31:0] d, input logic bd,
                       input logic crc, input logic eb, input logic rd);
    wr_valid_i    = wv;
    wr_data_i     = d;
    block_done_i  = bd;
    crc_err_i     = crc;
    end_bit_err_i = eb;
    rd_en_i       = rd;
    step();
    wr_valid_i    = 1'b0;
    wr_data_i     = '0;
    block_done_i  = 1'b0;
    crc_err_i     = 1'b0;
    end_bit_err_i = 1'b0;
    rd_en_i       = 1'b0;
  endtask

  task automatic write_good(input logic [31:0] d, input logic bd);
    exp_q.push_back(d);
    drive(1'b1, d, bd, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard read: compare head word, read it, check the ready pulse,
  // then leave one idle cycle before the next read
  task automatic read_check(input logic exp_rdy);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
    check("rd_data", rd_data_o, e);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rd_ready_after_read", {31'b0, buf_rd_ready_o}, {31'b0, exp_rdy});
    check("no_underrun", {31'b0, underrun_o}, 32'h0);
    step();
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; block_size_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0; block_done_i = 1'b0;
    crc_err_i = 1'b0; end_bit_err_i = 1'b0; rd_en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rd_data", rd_data_o, 32'h0);
    check("rst_enable", {31'b0, buf_rd_enable_o}, 32'h0);
    check("rst_ready", {31'b0, buf_rd_ready_o}, 32'h0);
    check("rst_pause", {31'b0, pause_o}, 32'h0);
    check("rst_blk_err", {31'b0, blk_err_o}, 32'h0);
    check("rst_overflow", {31'b0, overflow_o}, 32'h0);
    check("rst_underrun", {31'b0, underrun_o}, 32'h0);
    rst_ni = 1'b1;
    step();

    // single 512-byte block
    block_size_i = 10'd512;
    for (int i = 0; i < 128; i++) write_good(32'h1000_0000 + 32'(i), 1'b0);
    check("t1_enable_before_done", {31'b0, buf_rd_enable_o}, 32'h0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_ready", {31'b0, buf_rd_ready_o}, 32'h1);
    check("t1_enable", {31'b0, buf_rd_enable_o}, 32'h1);
    check("t1_pause", {31'b0, pause_o}, 32'h0);
    step();
    check("t1_ready_one_cycle", {31'b0, buf_rd_ready_o}, 32'h0);
    for (int i = 0; i < 128; i++) read_check(1'b0);
    check("t1_enable_drop", {31'b0, buf_rd_enable_o}, 32'h0);
    check("t1_rd_data_zero", rd_data_o, 32'h0);

    // bad blocks are discarded
    block_size_i = 10'd8;
    write_good(32'hA000_0000, 1'b0);
    write_good(32'hA000_0001, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_a_ready", {31'b0, buf_rd_ready_o}, 32'h1);
    drive(1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_crc_blk_err", {31'b0, blk_err_o}, 32'h1);
    check("t2_enable", {31'b0, buf_rd_enable_o}, 32'h1);
    step();
    check("t2_blk_err_one_cycle", {31'b0, blk_err_o}, 32'h0);
    write_good(32'hC000_0000, 1'b0);
    write_good(32'hC000_0001, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_c_no_ready", {31'b0, buf_rd_ready_o}, 32'h0);
    check("t2_c_blk_err", {31'b0, blk_err_o}, 32'h0);
    drive(1'b1, 32'hE000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hE000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t2_endbit_blk_err", {31'b0, blk_err_o}, 32'h1);
    step();
    read_check(1'b0);
    read_check(1'b1);
    read_check(1'b0);
    read_check(1'b0);
    check("t2_enable_drop", {31'b0, buf_rd_enable_o}, 32'h0);
    check("t2_rd_data_zero", rd_data_o, 32'h0);

    // back-pressure with two maximum blocks
    block_size_i = 10'd512;
    for (int i = 0; i < 128; i++) write_good(32'h3100_0000 + 32'(i), 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_pause_after_first", {31'b0, pause_o}, 32'h0);
    for (int i = 0; i < 128; i++) write_good(32'h3200_0000 + 32'(i), 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_pause_after_second", {31'b0, pause_o}, 32'h1);
    check("t3_no_overflow", {31'b0, overflow_o}, 32'h0);
    for (int i = 0; i < 128; i++) begin
      read_check(i == 127);
      if (i == 63) check("t3_pause_mid", {31'b0, pause_o}, 32'h1);
    end
    check("t3_pause_released", {31'b0, pause_o}, 32'h0);
    check("t3_enable_still", {31'b0, buf_rd_enable_o}, 32'h1);
    for (int i = 0; i < 128; i++) read_check(1'b0);
    check("t3_enable_drop", {31'b0, buf_rd_enable_o}, 32'h0);

    // 5-byte block, last word coincides with block_done_i
    block_size_i = 10'd5;
    write_good(32'h4000_0000, 1'b0);
    write_good(32'h4000_0001, 1'b1);
    check("t4_ready", {31'b0, buf_rd_ready_o}, 32'h1);
    check("t4_enable", {31'b0, buf_rd_enable_o}, 32'h1);
    read_check(1'b0);
    read_check(1'b0);
    check("t4_enable_drop", {31'b0, buf_rd_enable_o}, 32'h0);

    // 10 blocks of 8 words, reads interleaved; each commit lands on the
    // cycle that finishes reading the previous block
    block_size_i = 10'd32;
    for (int k = 0; k < 8; k++) write_good(32'h5000_0000 + 32'(k), 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int b = 1; b < 10; b++) begin
      for (int k = 0; k < 16; k++) begin
        logic [31:0] d;
        logic        rd;
        d  = 32'h5000_0000 + 32'(b * 16 + k);
        rd = (k % 2 == 0);
        if (rd) check("t5_rd_data", rd_data_o, exp_q.pop_front());
        if (k < 8) exp_q.push_back(d);
        drive(k < 8, d, k == 14, 1'b0, 1'b0, rd);
        if (k == 14) begin
          check("t5_ready_on_swap", {31'b0, buf_rd_ready_o}, 32'h1);
          check("t5_enable_on_swap", {31'b0, buf_rd_enable_o}, 32'h1);
        end
      end
    end
    for (int k = 0; k < 8; k++) read_check(1'b0);
    check("t5_enable_drop", {31'b0, buf_rd_enable_o}, 32'h0);
    check("t5_queue_empty", 32'(exp_q.size()), 32'h0);

    // misuse: underrun, overflow, clear mid-block
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_underrun", {31'b0, underrun_o}, 32'h1);
    check("t6_underrun_data", rd_data_o, 32'h0);
    step();
    check("t6_underrun_one_cycle", {31'b0, underrun_o}, 32'h0);
    block_size_i = 10'd8;
    for (int i = 0; i < 256; i++) drive(1'b1, 32'h6000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_no_overflow_at_256", {31'b0, overflow_o}, 32'h0);
    drive(1'b1, 32'h6000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_overflow", {31'b0, overflow_o}, 32'h1);
    step();
    check("t6_overflow_sticky", {31'b0, overflow_o}, 32'h1);
    check("t6_enable_uncommitted", {31'b0, buf_rd_enable_o}, 32'h0);
    clear_i = 1'b1;
    drive(1'b1, 32'h6666_6666, 1'b1, 1'b0, 1'b0, 1'b0);
    clear_i = 1'b0;
    check("t6_clr_overflow", {31'b0, overflow_o}, 32'h0);
    check("t6_clr_enable", {31'b0, buf_rd_enable_o}, 32'h0);
    check("t6_clr_ready", {31'b0, buf_rd_ready_o}, 32'h0);
    check("t6_clr_pause", {31'b0, pause_o}, 32'h0);
    check("t6_clr_blk_err", {31'b0, blk_err_o}, 32'h0);
    check("t6_clr_underrun", {31'b0, underrun_o}, 32'h0);
    check("t6_clr_rd_data", rd_data_o, 32'h0);
    step();
    check("t6_clr_no_commit", {31'b0, buf_rd_enable_o}, 32'h0);
    write_good(32'h7000_0000, 1'b0);
    write_good(32'h7000_0001, 1'b1);
    check("t6_post_clear_ready", {31'b0, buf_rd_ready_o}, 32'h1);
    read_check(1'b0);
    read_check(1'b0);
    check("t6_post_clear_empty", {31'b0, buf_rd_enable_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
